lock_reg_bank_arbiter: RTL and testbench

//  Shares a bank of sticky-lockable config registers between NUM_REQ write requesters (CPU, DMA, debug).

---
 rtl/lock_reg_bank_arbiter_pkg.sv | 38 +++
 rtl/lock_reg_bank_arbiter_if.sv | 22 ++
 rtl/lock_reg_bank_arbiter_rr_arbiter.sv | 21 ++
 rtl/lock_reg_bank_arbiter.sv | 164 ++++++++++++++++
 tb/tb_lock_reg_bank_arbiter.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/lock_reg_bank_arbiter_pkg.sv
// Shared types, default widths and the round-robin search helper for the
// lockable config register bank.
package lock_reg_bank_arbiter_pkg;

  localparam int MAX_REQ      = 8;
  localparam int DEF_NUM_REQ  = 3;
  localparam int DEF_NUM_REGS = 4;
  localparam int DEF_DATA_W   = 16;
  localparam int DEF_ADDR_W   = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    COMMIT = 2'd2
  } state_e;

  // First set bit of req at or above ptr, wrapping modulo n; one-hot result.
  // Sized for the largest supported requester count so callers zero-extend.
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                                 input logic [3:0]         ptr,
                                                 input logic [3:0]         n);
    logic [MAX_REQ-1:0] oh;
    logic               found;
    logic [3:0]         k;
    oh    = '0;
    found = 1'b0;
    for (int i = 0; i < MAX_REQ; i++) begin
      k = ptr + 4'(i);
      if (k >= n) k = k - n;
      if ((4'(i) < n) && !found && req[k[2:0]]) begin
        oh[k[2:0]] = 1'b1;
        found      = 1'b1;
      end
    end
    return oh;
  endfunction

endpackage

// File: rtl/lock_reg_bank_arbiter_if.sv
// Requester-side bus: level requests with packed address/data, and the
// registered grant / ack / err pulses going back.
interface lock_reg_bank_arbiter_if
  import lock_reg_bank_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_trusted;
  logic [NUM_REQ-1:0]        gnt;
  logic                      ack;
  logic                      err;

  modport master (output req, req_addr, req_data, req_trusted,
                  input  gnt, ack, err);
  modport slave  (input  req, req_addr, req_data, req_trusted,
                  output gnt, ack, err);
endinterface

// File: rtl/lock_reg_bank_arbiter_rr_arbiter.sv
// Combinational round-robin picker: one-hot winner searching upward from ptr.
module rr_arbiter
  import lock_reg_bank_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic               valid
);
  logic [MAX_REQ-1:0] pick;

  // Widen to the helper's fixed size, then trim back to the live lanes.
  always_comb begin
    pick  = rr_pick(MAX_REQ'(req), 4'(ptr), 4'(NUM_REQ));
    gnt   = pick[NUM_REQ-1:0];
    valid = |req;
  end
endmodule

// File: rtl/lock_reg_bank_arbiter.sv
// Arbitrated writer into a bank of sticky-lockable config registers.
// One access per IDLE->GRANT->COMMIT pass; the lock policy is checked at the
// edge that enters COMMIT so ack/err and the new register value appear together.
module lock_reg_bank_arbiter
  import lock_reg_bank_arbiter_pkg::*;
#(
  parameter int NUM_REQ  = DEF_NUM_REQ,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W
) (
  input  logic                       Clk,
  input  logic                       resetn,
  lock_reg_bank_arbiter_if.slave     bus,
  input  logic                       debug_mode,
  input  logic [NUM_REGS-1:0]        lock_set,
  output logic [NUM_REGS*DATA_W-1:0] reg_q,
  output logic [NUM_REGS-1:0]        lock_q
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_e              state, state_d;
  logic [PTR_W-1:0]    rr_ptr, cap_idx, win_idx;
  logic [NUM_REQ-1:0]  win_oh;
  logic                win_vld;
  logic [ADDR_W-1:0]   cap_addr, win_addr;
  logic [DATA_W-1:0]   cap_data, win_data;
  logic                cap_trusted, win_trusted;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic                ack_q, ack_d, err_q, err_d;
  logic                cap_en, wr_en;
  logic                addr_ok, addr_locked;
  logic [NUM_REGS-1:0] lock_eff;
  logic [DATA_W-1:0]   bank [NUM_REGS];

  rr_arbiter #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_rr (
    .req   (bus.req),
    .ptr   (rr_ptr),
    .gnt   (win_oh),
    .valid (win_vld)
  );

  // Turn the one-hot winner into an index and mux out its request fields.
  always_comb begin
    win_idx     = '0;
    win_addr    = '0;
    win_data    = '0;
    win_trusted = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_oh[i]) begin
        win_idx     = PTR_W'(i);
        win_addr    = bus.req_addr[i*ADDR_W +: ADDR_W];
        win_data    = bus.req_data[i*DATA_W +: DATA_W];
        win_trusted = bus.req_trusted[i];
      end
    end
  end

  // FSM state register.
  always_ff @(posedge Clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_d;
  end

  // FSM next state: a single pass per access, no early exits.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (win_vld) state_d = GRANT;
      GRANT:   state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs and policy. A lock_set arriving on the commit edge counts as
  // already locked, so the lock always wins that race.
  always_comb begin
    lock_eff    = lock_q | lock_set;
    addr_ok     = ({1'b0, cap_addr} < (ADDR_W+1)'(NUM_REGS));
    addr_locked = 1'b0;
    for (int j = 0; j < NUM_REGS; j++)
      if ((cap_addr == ADDR_W'(j)) && lock_eff[j]) addr_locked = 1'b1;
    cap_en = 1'b0;
    wr_en  = 1'b0;
    gnt_d  = '0;
    ack_d  = 1'b0;
    err_d  = 1'b0;
    case (state)
      IDLE: if (win_vld) begin
        cap_en = 1'b1;
        gnt_d  = win_oh;
      end
      GRANT: begin
        if (addr_ok && !addr_locked && (!debug_mode || cap_trusted)) begin
          wr_en = 1'b1;
          ack_d = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Registered handshake pulses.
  always_ff @(posedge Clk or negedge resetn) begin
    if (!resetn) begin
      gnt_q <= '0;
      ack_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      gnt_q <= gnt_d;
      ack_q <= ack_d;
      err_q <= err_d;
    end
  end

  // Capture the winner so a requester may drop req once granted.
  always_ff @(posedge Clk or negedge resetn) begin
    if (!resetn) begin
      cap_idx     <= '0;
      cap_addr    <= '0;
      cap_data    <= '0;
      cap_trusted <= 1'b0;
    end else if (cap_en) begin
      cap_idx     <= win_idx;
      cap_addr    <= win_addr;
      cap_data    <= win_data;
      cap_trusted <= win_trusted;
    end
  end

  // Rotate priority past the requester just served.
  always_ff @(posedge Clk or negedge resetn) begin
    if (!resetn)              rr_ptr <= '0;
    else if (state == GRANT)  rr_ptr <= (cap_idx == PTR_W'(NUM_REQ-1)) ? '0
                                                                      : cap_idx + PTR_W'(1);
  end

  // Register bank: only a policy-approved commit writes.
  always_ff @(posedge Clk or negedge resetn) begin
    if (!resetn) begin
      for (int j = 0; j < NUM_REGS; j++) bank[j] <= '0;
    end else if (wr_en) begin
      for (int j = 0; j < NUM_REGS; j++)
        if (cap_addr == ADDR_W'(j)) bank[j] <= cap_data;
    end
  end

  // Sticky locks: set-only, cleared solely by reset.
  always_ff @(posedge Clk or negedge resetn) begin
    if (!resetn) lock_q <= '0;
    else         lock_q <= lock_q | lock_set;
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regq
    assign reg_q[g*DATA_W +: DATA_W] = bank[g];
  end

  assign bus.gnt = gnt_q;
  assign bus.ack = ack_q;
  assign bus.err = err_q;
endmodule

// File: tb/tb_lock_reg_bank_arbiter.sv
// Randomized bench for lock_reg_bank_arbiter with a transaction-level model:
// register/lock arrays and a rotating priority index.
module tb_lock_reg_bank_arbiter;
  localparam int N  = 3;
  localparam int R  = 4;
  localparam int DW = 16;
  localparam int AW = 2;

  logic            Clk;
  logic            resetn;
  logic            debug_mode;
  logic [R-1:0]    lock_set;
  logic [R*DW-1:0] reg_q;
  logic [R-1:0]    lock_q;

  lock_reg_bank_arbiter_if #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW)) bus ();

  lock_reg_bank_arbiter #(.NUM_REQ(N), .NUM_REGS(R), .DATA_W(DW), .ADDR_W(AW)) dut (
    .Clk        (Clk),
    .resetn     (resetn),
    .bus        (bus),
    .debug_mode (debug_mode),
    .lock_set   (lock_set),
    .reg_q      (reg_q),
    .lock_q     (lock_q)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int          nvec;
  int          nerr;
  logic [15:0] m_reg [R];
  logic [R-1:0] m_lock;
  int          m_ptr;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [R*DW-1:0] m_regq();
    logic [R*DW-1:0] v;
    for (int j = 0; j < R; j++) v[j*DW +: DW] = m_reg[j];
    return v;
  endfunction

  function automatic int m_pick(input logic [N-1:0] r);
    for (int i = 0; i < N; i++)
      if (r[(m_ptr + i) % N]) return (m_ptr + i) % N;
    return -1;
  endfunction

  function automatic void m_clear();
    for (int j = 0; j < R; j++) m_reg[j] = '0;
    m_lock = '0;
    m_ptr  = 0;
  endfunction

  // Reset with garbage on every input; outputs must read as cleared.
  task automatic do_reset();
    resetn          = 1'b0;
    bus.req         = N'($urandom);
    bus.req_addr    = (N*AW)'($urandom);
    bus.req_data    = {$urandom, $urandom};
    bus.req_trusted = N'($urandom);
    debug_mode      = 1'($urandom);
    lock_set        = R'($urandom);
    @(negedge Clk);
    @(negedge Clk);
    chk("rst_gnt",  64'(bus.gnt), 64'd0);
    chk("rst_ack",  64'(bus.ack), 64'd0);
    chk("rst_err",  64'(bus.err), 64'd0);
    chk("rst_regq", 64'(reg_q),   64'd0);
    chk("rst_lock", 64'(lock_q),  64'd0);
    resetn   = 1'b1;
    bus.req  = '0;
    lock_set = '0;
    m_clear();
  endtask

  task automatic pulse_lock(input logic [R-1:0] m);
    lock_set = m;
    @(negedge Clk);
    m_lock |= m;
    lock_set = '0;
    chk("lock_pulse", 64'(lock_q), 64'(m_lock));
  endtask

  // One full access; fields change after the grant to prove they were captured.
  // dbg and ls are presented on the commit edge.
  task automatic access(input logic [N-1:0] rv, input logic [N*AW-1:0] ap,
                        input logic [N*DW-1:0] dp, input logic [N-1:0] tp,
                        input logic dbg, input logic [R-1:0] ls);
    int          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic        t, ok;
    w = m_pick(rv);
    a = ap[w*AW +: AW];
    d = dp[w*DW +: DW];
    t = tp[w];
    bus.req = rv; bus.req_addr = ap; bus.req_data = dp; bus.req_trusted = tp;
    debug_mode = 1'($urandom);
    lock_set   = '0;
    @(negedge Clk);
    chk("gnt", 64'(bus.gnt), 64'(1) << w);
    chk("ack_in_grant", 64'(bus.ack), 64'd0);
    chk("err_in_grant", 64'(bus.err), 64'd0);
    bus.req = N'($urandom); bus.req_addr = (N*AW)'($urandom);
    bus.req_data = {$urandom, $urandom}; bus.req_trusted = N'($urandom);
    debug_mode = dbg;
    lock_set   = ls;
    @(negedge Clk);
    m_lock |= ls;
    ok = (int'(a) < R) && !m_lock[a] && (!dbg || t);
    if (ok) m_reg[a] = d;
    m_ptr = (w + 1) % N;
    chk("ack", 64'(bus.ack), 64'(ok));
    chk("err", 64'(bus.err), 64'(!ok));
    chk("gnt_commit", 64'(bus.gnt), 64'd0);
    chk("regq", 64'(reg_q), 64'(m_regq()));
    chk("lockq", 64'(lock_q), 64'(m_lock));
    bus.req  = '0;
    lock_set = '0;
    @(negedge Clk);
    chk("ack_idle", 64'(bus.ack), 64'd0);
    chk("err_idle", 64'(bus.err), 64'd0);
  endtask

  initial begin
    logic [N-1:0]    rv;
    logic [N*DW-1:0] dp;
    int              w;
    nvec = 0;
    nerr = 0;
    m_clear();

    // T1 reset
    do_reset();

    // T2 basic write from requester 0
    access(3'b001, {2'd0, 2'd0, 2'd1}, {16'h0, 16'h0, 16'hA5A5}, 3'b000, 1'b0, '0);
    chk("t2_reg1", 64'(reg_q[1*DW +: DW]), 64'hA5A5);

    // T3 round robin with req held high for 9 cycles
    do_reset();
    dp = {$urandom, $urandom};
    bus.req = 3'b111; bus.req_addr = {2'd2, 2'd1, 2'd0}; bus.req_data = dp;
    bus.req_trusted = 3'b111; debug_mode = 1'b0; lock_set = '0;
    w = 0;
    for (int k = 0; k < 9; k++) begin
      @(negedge Clk);
      if (k % 3 == 0) begin
        w = m_pick(3'b111);
        chk("rr_gnt", 64'(bus.gnt), 64'(1) << w);
      end else if (k % 3 == 1) begin
        m_reg[w] = dp[w*DW +: DW];
        m_ptr = (w + 1) % N;
        chk("rr_ack", 64'(bus.ack), 64'd1);
        chk("rr_regq", 64'(reg_q), 64'(m_regq()));
      end else begin
        chk("rr_gap", 64'(bus.gnt), 64'd0);
      end
    end
    bus.req = '0;
    @(negedge Clk);

    // T4 locked register resists trusted debug writes
    pulse_lock(4'b0100);
    access(3'b010, {2'd0, 2'd2, 2'd0}, {16'h0, 16'h1234, 16'h0}, 3'b010, 1'b1, '0);

    // T5 debug mode: untrusted rejected, trusted accepted
    access(3'b100, {2'd0, 2'd0, 2'd0}, {16'hBEEF, 16'h0, 16'h0}, 3'b000, 1'b1, '0);
    access(3'b001, {2'd0, 2'd0, 2'd0}, {16'h0, 16'h0, 16'hC0DE}, 3'b001, 1'b1, '0);

    // T6 lock arrives on the commit edge of a write to the same register
    access(3'b010, {2'd0, 2'd3, 2'd0}, {16'h0, 16'h7777, 16'h0}, 3'b010, 1'b0, 4'b1000);
    chk("t6_lock3", 64'(lock_q[3]), 64'd1);

    // T6 reset during GRANT aborts the access silently
    bus.req = 3'b100; bus.req_addr = {2'd1, 2'd0, 2'd0};
    bus.req_data = {16'h5555, 16'h0, 16'h0}; bus.req_trusted = 3'b100;
    @(negedge Clk);
    chk("abort_gnt", 64'(bus.gnt), 64'b100);
    resetn = 1'b0;
    #1;
    m_clear();
    chk("abort_gnt_clr", 64'(bus.gnt), 64'd0);
    chk("abort_regq", 64'(reg_q), 64'd0);
    chk("abort_lock", 64'(lock_q), 64'd0);
    @(negedge Clk);
    chk("abort_ack", 64'(bus.ack), 64'd0);
    chk("abort_err", 64'(bus.err), 64'd0);
    resetn = 1'b1;
    bus.req = '0;
    @(negedge Clk);
    chk("abort_ack2", 64'(bus.ack), 64'd0);
    chk("abort_err2", 64'(bus.err), 64'd0);

    // Random epochs, each from a fresh reset so locks do not saturate
    for (int ep = 0; ep < 4; ep++) begin
      do_reset();
      for (int t = 0; t < 30; t++) begin
        rv = N'($urandom_range(1, 7));
        access(rv, (N*AW)'($urandom), {$urandom, $urandom}, N'($urandom), 1'($urandom),
               ($urandom_range(0, 5) == 0) ? R'(1 << $urandom_range(0, R-1)) : '0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
